// File: rtl/board_row_fetcher.sv
// board_row_fetcher
//   Arbitrates the single-port board RAM (ROWS x COLS cells, DATA_W bits each)
//   between two requesters:
//     - the display path (LD_Row/rowNum), which always wins and burst-reads a
//       whole row into a shadow buffer. The buffer is then published to Row in
//       one step, and rowReady pulses.
//     - the game logic, which gets single-cell reads and writes in the
//       remaining IDLE cycles.
//   Ports:
//     Clk, reset (synchronous, active-low)
//     LD_Row, rowNum                 : row-load request / row number
//     Row, rowReady, busy            : published row, publish pulse, activity
//     game_req/we/row/col/wdata      : game access request (held until gnt)
//     game_gnt, game_rvalid, game_rdata : grant (comb), read response
//     ram_addr, ram_we, ram_wdata, ram_rdata : RAM port (1-cycle read latency)
module board_row_fetcher #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int DATA_W = 16
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         LD_Row,
  input  logic [7:0]                   rowNum,
  output logic [COLS-1:0][DATA_W-1:0]  Row,
  output logic                         rowReady,
  output logic                         busy,
  input  logic                         game_req,
  input  logic                         game_we,
  input  logic [4:0]                   game_row,
  input  logic [3:0]                   game_col,
  input  logic [DATA_W-1:0]            game_wdata,
  output logic                         game_gnt,
  output logic                         game_rvalid,
  output logic [DATA_W-1:0]            game_rdata,
  output logic [7:0]                   ram_addr,
  output logic                         ram_we,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata
);

  localparam int               COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [7:0]       ROWS8    = 8'(ROWS);
  localparam logic [7:0]       COLS8    = 8'(COLS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                       state_reg, state_next;
  logic [COL_W-1:0]             col_reg, col_next;
  logic [7:0]                   row_reg, row_next;
  logic                         pend_reg, pend_next;
  logic [7:0]                   pend_row_reg, pend_row_next;
  logic [COLS-1:0][DATA_W-1:0]  shadow_reg;
  logic                         rd_valid_reg;
  logic                         rd_oor_reg;
  logic [DATA_W-1:0]            rdata_hold_reg;

  logic [7:0] ld_row_eff;
  logic       game_oor;

  function automatic logic [7:0] cell_addr(input logic [7:0] r, input logic [7:0] c);
    return 8'(r * COLS8 + c);
  endfunction

  // Out-of-range row numbers from the display side fold to row 0.
  assign ld_row_eff = (rowNum >= ROWS8) ? 8'd0 : rowNum;
  assign game_oor   = ({3'b0, game_row} >= ROWS8) || ({4'b0, game_col} >= COLS8);

  assign busy = (state_reg != IDLE) || pend_reg;

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    pend_next     = pend_reg;
    pend_row_next = pend_row_reg;
    ram_addr      = 8'd0;
    ram_we        = 1'b0;
    ram_wdata     = '0;
    game_gnt      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_reg || LD_Row) begin
          // A waiting load is served first; a simultaneous new request
          // takes its place in the single-deep pending slot.
          if (pend_reg) begin
            row_next  = pend_row_reg;
            pend_next = LD_Row;
            if (LD_Row) pend_row_next = ld_row_eff;
          end else begin
            row_next = ld_row_eff;
          end
          ram_addr   = cell_addr(row_next, 8'd0);
          col_next   = COL_W'(1);
          state_next = FETCH;
        end else if (game_req && reset) begin
          game_gnt = 1'b1;
          if (!game_oor) begin
            ram_addr  = cell_addr({3'b0, game_row}, {4'b0, game_col});
            ram_we    = game_we;
            ram_wdata = game_wdata;
          end
        end
      end
      FETCH: begin
        ram_addr = cell_addr(row_reg, 8'(col_reg));
        if (col_reg == COL_LAST) begin
          state_next = DRAIN;
          col_next   = '0;
        end else begin
          col_next = col_reg + COL_W'(1);
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Requests arriving while busy collapse into one pending load (latest wins).
    if (state_reg != IDLE && LD_Row) begin
      pend_next     = 1'b1;
      pend_row_next = ld_row_eff;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= 8'd0;
      pend_reg       <= 1'b0;
      pend_row_reg   <= 8'd0;
      shadow_reg     <= '0;
      Row            <= '0;
      rowReady       <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_oor_reg     <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      pend_reg     <= pend_next;
      pend_row_reg <= pend_row_next;
      rowReady     <= (state_reg == DRAIN);

      // RAM data lags the address by one cycle, so a FETCH cycle with col=n
      // receives the word for col n-1.
      if (state_reg == FETCH) shadow_reg[col_reg - COL_W'(1)] <= ram_rdata;
      if (state_reg == DRAIN) begin
        shadow_reg[COLS-1] <= ram_rdata;
        Row                <= {ram_rdata, shadow_reg[COLS-2:0]};
      end

      rd_valid_reg <= game_gnt && !game_we;
      rd_oor_reg   <= game_oor;
      if (rd_valid_reg) rdata_hold_reg <= game_rdata;
    end
  end

  // Read data arrives from the RAM in the cycle after the grant; outside
  // that cycle the last returned value is held.
  assign game_rvalid = rd_valid_reg;
  assign game_rdata  = rd_valid_reg ? (rd_oor_reg ? '0 : ram_rdata) : rdata_hold_reg;

endmodule

// File: tb/tb_board_row_fetcher.sv
// tb_board_row_fetcher
//   Self-checking bench for board_row_fetcher. It contains a behavioural RAM
//   and a reference board model. Expected rows and read data are queued when
//   stimulus is issued. A negedge monitor pops the queues and compares them
//   against rowReady/Row and game_rvalid/game_rdata.
module tb_board_row_fetcher;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int DW   = 16;
  typedef logic [COLS-1:0][DW-1:0] row_t;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          LD_Row = 1'b0;
  logic [7:0]    rowNum = 8'd0;
  row_t          Row;
  logic          rowReady, busy;
  logic          game_req = 1'b0, game_we = 1'b0;
  logic [4:0]    game_row = 5'd0;
  logic [3:0]    game_col = 4'd0;
  logic [DW-1:0] game_wdata = '0;
  logic          game_gnt, game_rvalid;
  logic [DW-1:0] game_rdata;
  logic [7:0]    ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:ROWS*COLS-1];
  logic [DW-1:0] board [ROWS][COLS];

  row_t          exp_rows[$];
  logic [DW-1:0] exp_rd[$];
  row_t          exp_pub;
  logic [DW-1:0] last_rdata, e;
  int            tests = 0, fails = 0, cyc = 0;
  int            rr_cyc[$];
  bit            mon_en = 1'b0;

  board_row_fetcher #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) dut (
    .Clk(Clk), .reset(reset), .LD_Row(LD_Row), .rowNum(rowNum),
    .Row(Row), .rowReady(rowReady), .busy(busy),
    .game_req(game_req), .game_we(game_we), .game_row(game_row),
    .game_col(game_col), .game_wdata(game_wdata),
    .game_gnt(game_gnt), .game_rvalid(game_rvalid), .game_rdata(game_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Board RAM with registered read.
  always @(posedge Clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic int eff_row(input int r);
    return (r >= ROWS) ? 0 : r;
  endfunction

  function automatic row_t row_of(input int r);
    row_t x;
    for (int c = 0; c < COLS; c++) x[c] = board[eff_row(r)][c];
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Monitor: scoreboard pops plus continuous invariants.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (rowReady) begin
        rr_cyc.push_back(cyc);
        tests++;
        if (exp_rows.size() == 0) begin
          fails++;
          $display("FAIL row_ready_unexpected: got rowReady in cycle %0d, required none", cyc);
        end else begin
          exp_pub = exp_rows.pop_front();
        end
      end
      tests++;
      if (Row !== exp_pub) begin
        fails++;
        $display("FAIL row_contents: got %h, required %h", Row, exp_pub);
      end
      if (game_rvalid) begin
        tests++;
        if (exp_rd.size() == 0) begin
          fails++;
          $display("FAIL rvalid_unexpected: got game_rvalid with data %h, required none", game_rdata);
        end else begin
          e = exp_rd.pop_front();
          last_rdata = e;
          if (game_rdata !== e) begin
            fails++;
            $display("FAIL game_rdata: got %h, required %h", game_rdata, e);
          end
        end
      end else begin
        tests++;
        if (game_rdata !== last_rdata) begin
          fails++;
          $display("FAIL rdata_hold: got %h, required %h", game_rdata, last_rdata);
        end
      end
      if (ram_we) begin
        tests++;
        if (!(game_gnt && game_we)) begin
          fails++;
          $display("FAIL ram_we_without_grant: got ram_we=1 gnt=%0b we=%0b, required gnt=1 we=1", game_gnt, game_we);
        end
      end
    end
  end

  task automatic ld_pulse(input int r, input bit expect_it);
    LD_Row = 1'b1;
    rowNum = 8'(r);
    if (expect_it) exp_rows.push_back(row_of(r));
    $display("[TB] load row %0d (expected publish=%0b)", r, expect_it);
    @(posedge Clk); #1;
    LD_Row = 1'b0;
  endtask

  task automatic game_op(input bit we, input int r, input int c, input logic [DW-1:0] wd,
                         output int waited);
    bit oor;
    oor = (r >= ROWS) || (c >= COLS);
    game_req = 1'b1; game_we = we; game_row = 5'(r); game_col = 4'(c); game_wdata = wd;
    waited = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (game_gnt) begin
        waited = k;
        break;
      end
    end
    if (waited < 0) begin
      tests++; fails++;
      $display("FAIL game_gnt_timeout: got no grant in 40 cycles for (%0d,%0d), required grant", r, c);
    end else if (we) begin
      check("ram_we_on_write", ram_we, oor ? 0 : 1);
      if (!oor) begin
        check("ram_addr_on_write", ram_addr, r * COLS + c);
        board[r][c] = wd;
      end
    end else begin
      exp_rd.push_back(oor ? '0 : board[r][c]);
    end
    $display("[TB] game %s (%0d,%0d) data %h waited %0d", we ? "write" : "read", r, c, wd, waited);
    @(posedge Clk); #1;
    game_req = 1'b0; game_we = 1'b0;
    if (!we && waited >= 0) begin
      @(negedge Clk);
      check("rvalid_latency", game_rvalid, 1);
      @(posedge Clk); #1;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_rows.size() != 0 || exp_rd.size() != 0) && k < 200) begin
      @(negedge Clk);
      k++;
    end
    check("drain_timeout", (k >= 200) ? 1 : 0, 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, sel, r;
    bit last_load;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++) begin
        mem[rr*COLS+cc] = 16'(rr * 256 + cc);
        board[rr][cc]   = 16'(rr * 256 + cc);
      end
    exp_pub = '0;
    last_rdata = '0;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("reset_rowReady", rowReady, 0);
    check("reset_busy", busy, 0);
    check("reset_gnt", game_gnt, 0);
    check("reset_rvalid", game_rvalid, 0);
    check("reset_ram_we", ram_we, 0);
    check("reset_ram_addr", ram_addr, 0);
    check("reset_rdata", game_rdata, 0);
    check("reset_row_zero", (Row == '0) ? 1 : 0, 1);
    @(posedge Clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // Load row 7: rowReady exactly 11 cycles after the request.
    LD_Row = 1'b1; rowNum = 8'd7; exp_rows.push_back(row_of(7));
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (rowReady) begin
        lat = k;
        break;
      end
      if (k == 3) check("busy_in_fetch", busy, 1);
      if (k == 0) begin
        @(posedge Clk); #1;
        LD_Row = 1'b0;
      end
    end
    check("load_latency", lat, 11);
    $display("[TB] load row 7 latency %0d", lat);
    wait_done();

    // Load and game read in the same cycle: display wins.
    fork
      ld_pulse(3, 1'b1);
      game_op(1'b0, 5, 5, '0, w);
    join
    check("gnt_wait_behind_load", w, 11);
    wait_done();

    // Two requests during a fetch collapse to the latest one.
    rr_cyc.delete();
    ld_pulse(2, 1'b1);
    ld_pulse(4, 1'b0);
    @(posedge Clk); #1;
    ld_pulse(9, 1'b1);
    wait_done();
    check("row_ready_count", rr_cyc.size(), 2);
    if (rr_cyc.size() == 2) check("row_ready_spacing", rr_cyc[1] - rr_cyc[0], 11);

    // Out-of-range row numbers fold to row 0.
    ld_pulse(20, 1'b1);
    wait_done();
    ld_pulse(5, 1'b1);
    wait_done();
    ld_pulse(255, 1'b1);
    wait_done();

    // Game write visible to a later load; out-of-range accesses.
    game_op(1'b1, 0, 0, 16'h0F00, w);
    ld_pulse(0, 1'b1);
    wait_done();
    check("row0_cell0_after_write", Row[0], 16'h0F00);
    game_op(1'b1, 20, 3, 16'hABCD, w);
    game_op(1'b0, 1, 12, '0, w);
    wait_done();

    // Randomized mix; never two loads back to back, so none collapse.
    last_load = 1'b0;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0 && !last_load) begin
        r = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 255) : $urandom_range(0, ROWS - 1);
        ld_pulse(r, 1'b1);
        last_load = 1'b1;
      end else begin
        game_op(1'($urandom_range(0, 1)), $urandom_range(0, 21), $urandom_range(0, 11),
                16'($urandom_range(0, 4095)), w);
        last_load = 1'b0;
      end
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        @(posedge Clk); #1;
      end
    end
    wait_done();

    // Reset in the middle of a fetch aborts it.
    rr_cyc.delete();
    ld_pulse(6, 1'b1);
    repeat (4) begin
      @(posedge Clk); #1;
    end
    reset = 1'b0;
    exp_rows.delete();
    @(posedge Clk); #1;
    reset = 1'b1;
    exp_pub = '0;
    last_rdata = '0;
    @(negedge Clk);
    check("busy_after_reset", busy, 0);
    check("row_zero_after_reset", (Row == '0) ? 1 : 0, 1);
    check("rdata_after_reset", game_rdata, 0);
    @(posedge Clk); #1;
    game_op(1'b0, 4, 4, '0, w);
    check("gnt_immediate_after_reset", w, 0);
    repeat (15) begin
      @(posedge Clk); #1;
    end
    check("no_row_ready_after_abort", rr_cyc.size(), 0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_row_fetcher.md
# board_row_fetcher

Sequences and arbitrates the single-port board RAM: 20 rows × 10 cells × 16-bit {4'b0, R[3:0], G[3:0], B[3:0]} words. It serves two requesters. The color mapper's row-load requests (`LD_Row`/`rowNum`) have priority and burst-read a full row into a shadow buffer, which is then published atomically as `Row[10]` with a `rowReady` pulse. Game-logic single-cell reads and writes share the remaining RAM cycles. The block sits between the board RAM, the game logic and `color_mapper`.

## Interface
- `COLS`, default 10: cells per row
- `ROWS`, default 20: rows per board
- `DATA_W`, default 16: cell word width
- `Clk`, in, 1: system clock; all state updates on the rising edge
- `reset`, in, 1: synchronous, active-low
- `LD_Row`, in, 1: display row-load request, sampled every cycle
- `rowNum`, in, 8: row to load; values ≥ ROWS are treated as row 0
- `Row`, out, [COLS][DATA_W]: published row, registered
- `rowReady`, out, 1: one-cycle pulse; `Row` holds the new row from this cycle onward
- `busy`, out, 1: high in FETCH/DRAIN or while a load is pending
- `game_req`, in, 1: game access request; must be held until granted
- `game_we`, in, 1: 1 = write, 0 = read
- `game_row`, in, 5; `game_col`, in, 4: cell coordinates
- `game_wdata`, in, DATA_W: write data
- `game_gnt`, out, 1: combinational; access performed this cycle
- `game_rvalid`, out, 1: pulse one cycle after a granted read
- `game_rdata`, out, DATA_W: read data, valid with `game_rvalid`, held otherwise
- `ram_addr`, out, 8: row*COLS+col, range 0..199
- `ram_we`, out, 1; `ram_wdata`, out, DATA_W: RAM write port
- `ram_rdata`, in, DATA_W: RAM read data, one-cycle latency

## Operation
- FSM states:
  - IDLE
  - FETCH: issuing addresses for col 0..COLS-1
  - DRAIN: capturing the last word, then publishing
- IDLE:
  - If `LD_Row` or the pending flag is set, latch the row (pending row takes precedence over a new `LD_Row`, which becomes pending). Drive `ram_addr` = row*COLS+0, set col = 1, go to FETCH.
  - Otherwise, if `game_req` is high, assert `game_gnt` and drive the RAM with the game access.
- FETCH:
  - Each cycle, drive the address for the current col and capture `ram_rdata` into shadow[col-1].
  - After issuing col COLS-1, go to DRAIN.
- DRAIN:
  - Capture shadow[COLS-1].
  - Copy the full shadow buffer to `Row` at the end of the cycle.
  - Assert `rowReady` in the next cycle; return to IDLE.
- `LD_Row` outside IDLE sets the single-deep pending flag and latches `rowNum`. A later `LD_Row` before service overwrites the latched `rowNum` (latest wins).
- Display always wins. `game_gnt` is never asserted in FETCH or DRAIN, or in a cycle where IDLE starts a fetch.
- Game out-of-range access (row ≥ ROWS or col ≥ COLS): granted, `ram_we` suppressed, read returns 0.
- `ram_we` is high only in a cycle where `game_gnt` and `game_we` are both high.
- Address arithmetic is 8-bit and unsigned; no wrap occurs for legal inputs.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE; pending and col are cleared.
  - `Row` all 0, shadow all 0.
  - `rowReady`, `busy`, `game_gnt`, `game_rvalid`, `ram_we` = 0; `ram_addr` = 0; `game_rdata` = 0.
- Reset mid-fetch aborts the fetch: no `rowReady`, `Row` is cleared.
- Row-load latency: `LD_Row` sampled in IDLE at cycle 0:
  - Addresses are driven in cycles 0..9.
  - Shadow captures occur in cycles 1..10.
  - `Row` is updated at the end of cycle 10.
  - `rowReady` pulses in cycle 11.
  - Total: 11 cycles.
- `Row` never changes except in the single update at the end of DRAIN (no tearing).
- Pending load after DRAIN: a new FETCH begins in the `rowReady` cycle itself, so back-to-back loads take 11 cycles each.
- Game read: `game_gnt` in cycle N; `game_rvalid`/`game_rdata` in cycle N+1.
- Game write: takes effect in cycle N.
- Maximum game wait: 11 cycles, plus a further 11 if a load is pending.

## Test plan
- Preload RAM with cell = {row,col}. Pulse `LD_Row`, `rowNum`=7 in IDLE → `rowReady` exactly 11 cycles later; `Row[c]` = {7,c} for c = 0..9; `Row` unchanged before that cycle.
- `LD_Row` (`rowNum`=3) and `game_req` read (5,5) in the same cycle → fetch of row 3 wins; `game_gnt` first high in cycle 11; `game_rvalid` in cycle 12 with data {5,5}.
- During a fetch of row 2, pulse `LD_Row` with `rowNum`=4, then again with `rowNum`=9 → exactly two `rowReady` pulses, 11 cycles apart; the second `Row` = row 9.
- `LD_Row` with `rowNum`=20 and with `rowNum`=255 → `Row` = row 0 contents each time.
- Game write 16'h0F00 to (0,0), then a load of row 0 → `Row[0]`=16'h0F00. Game write to (20,3) → `ram_we` stays 0; game read of (1,12) → `game_rdata`=0.
- Assert reset during FETCH cycle 5 → no `rowReady`, `Row` all 0, state IDLE. First game request after reset is granted immediately.
